// File: rtl/apb_resp_pkg.sv
// apb_resp_pkg: shared FSM state type and constants for the APB responder memory
// Contents: state_t (IDLE/WAIT/DONE), WCNT_W wait-counter width, MISALIGN_MASK byte-offset mask.
package apb_resp_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam int WCNT_W = 4;
    localparam logic [1:0] MISALIGN_MASK = 2'b11;
endpackage

// File: rtl/apb_resp_ram.sv
// apb_resp_ram: single-port 32-bit RAM with write enable and registered (synchronous) read
// Ports: i_clk clock; i_we write enable; i_addr word address; i_wdata write word; o_rdata word read at the last edge.
// Contents are deliberately not reset.
module apb_resp_ram #(
    parameter int AW = 8
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [0:(1<<AW)-1];
    logic [31:0] r_rdata;
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        r_rdata <= r_mem[i_addr];
    end
    assign o_rdata = r_rdata;
endmodule

// File: rtl/apb_resp_mem.sv
// apb_resp_mem: APB responder backed by a word RAM, with optional wait states and a transfer counter
// Ports: i_pclk clock; i_presetn async active-low reset; i_psel/i_penable/i_pwrite/i_paddr/i_pwdata APB request;
//        o_prdata/o_pready/o_pslverr APB response; o_xfer_cnt completed transfers (errors included, wraps at 16 bits).
// Build option: APB_RESP_WAIT_STATES_EN defined honours WAIT_CYCLES; undefined behaves as zero wait states.
module apb_resp_mem
    import apb_resp_pkg::*;
#(
    parameter int AWIDTH      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              i_pclk,
    input  logic              i_presetn,
    input  logic              i_psel,
    input  logic              i_penable,
    input  logic              i_pwrite,
    input  logic [AWIDTH-1:0] i_paddr,
    input  logic [31:0]       i_pwdata,
    output logic [31:0]       o_prdata,
    output logic              o_pready,
    output logic              o_pslverr,
    output logic [15:0]       o_xfer_cnt
);
    state_t      r_state;
    state_t      w_state_nxt;
    state_t      w_first;
    logic        r_pready;
    logic        r_pslverr;
    logic        r_rd_ok;
    logic [15:0] r_xfer_cnt;
    logic [31:0] w_rdata;
    logic        w_setup;
    logic        w_mis;
    logic        w_complete;
    logic        w_we;
    logic        w_wait_done;

    assign w_setup    = i_psel & ~i_penable;
    assign w_mis      = |(i_paddr[1:0] & MISALIGN_MASK);
    assign w_complete = r_pready & i_psel & i_penable;
    assign w_we       = w_complete & i_pwrite & ~w_mis;

`ifdef APB_RESP_WAIT_STATES_EN
    logic [WCNT_W-1:0] r_wcnt;
    logic [WCNT_W-1:0] w_wcnt_nxt;
    assign w_wcnt_nxt = (r_state == IDLE && w_setup) ? WCNT_W'(WAIT_CYCLES)
                      : (r_state == WAIT && i_psel && i_penable) ? r_wcnt - 1'b1
                      : r_wcnt;
    always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn) r_wcnt <= '0;
        else            r_wcnt <= w_wcnt_nxt;
    end
    // PREADY is registered, so the FSM must already be in DONE during the
    // PREADY cycle; with no wait states that means skipping WAIT entirely.
    assign w_first     = (WAIT_CYCLES == 0) ? DONE : WAIT;
    assign w_wait_done = (w_wcnt_nxt == '0);
`else
    localparam int unused_wait_cycles = WAIT_CYCLES;
    assign w_first     = DONE;
    assign w_wait_done = 1'b1;
`endif

    // A set PENABLE in IDLE is not a setup phase and is ignored; DONE always
    // returns to IDLE so a new setup the following cycle is accepted.
    assign w_state_nxt = (r_state == IDLE) ? (w_setup ? w_first : IDLE)
                       : (r_state == WAIT && i_psel) ? (w_wait_done ? DONE : WAIT)
                       : IDLE;

    always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn) begin
            r_state    <= IDLE;
            r_pready   <= 1'b0;
            r_pslverr  <= 1'b0;
            r_rd_ok    <= 1'b0;
            r_xfer_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pready   <= w_state_nxt == DONE;
            r_pslverr  <= w_state_nxt == DONE && w_mis;
            r_rd_ok    <= w_state_nxt == DONE && !w_mis && !i_pwrite;
            if (w_complete) r_xfer_cnt <= r_xfer_cnt + 16'd1;
        end
    end

    // The RAM read is issued on the edge entering DONE so its registered
    // output lines up with PREADY; the address is stable for the transfer.
    apb_resp_ram #(.AW(AWIDTH-2)) u_ram (
        .i_clk   (i_pclk),
        .i_we    (w_we),
        .i_addr  (i_paddr[AWIDTH-1:2]),
        .i_wdata (i_pwdata),
        .o_rdata (w_rdata)
    );

    assign o_prdata   = r_rd_ok ? w_rdata : '0;
    assign o_pready   = r_pready;
    assign o_pslverr  = r_pslverr;
    assign o_xfer_cnt = r_xfer_cnt;
endmodule

// File: doc/apb_resp_mem.md
APB_RESP_MEM -- requirements
Module: apb_resp_mem

Interface
REQ-001 SHALL have parameter AWIDTH, default 10: byte-address width of PADDR; memory holds 2^(AWIDTH-2) 32-bit words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: wait states inserted per transfer, legal range 0..15.
REQ-003 SHALL have one clock and an asynchronous active-low reset: PCLK and PRESETN.
REQ-004 PCLK  input  1  rising-edge clock for all state.
REQ-005 PRESETN  input  1  asynchronous active-low reset.
REQ-006 PSEL  input  1  responder selected.
REQ-007 PENABLE  input  1  access phase.
REQ-008 PWRITE  input  1  1=write, 0=read.
REQ-009 PADDR  input  AWIDTH  byte address.
REQ-010 PWDATA  input  32  write data.
REQ-011 PRDATA  output  32  read data, valid only when PREADY=1 in a read access.
REQ-012 PREADY  output  1  transfer completes this cycle.
REQ-013 PSLVERR  output  1  error response, valid only with PREADY=1.
REQ-014 XFER_CNT  output  16  count of completed transfers, error responses included.

Function
REQ-015 SHALL implement a three-state FSM:
- IDLE -> WAIT on PSEL=1 & PENABLE=0 (setup phase).
- WAIT -> DONE when the wait counter reaches 0.
- DONE -> IDLE after one cycle.
- WAIT or DONE -> IDLE whenever PSEL=0 (abort).
REQ-016 SHALL load the wait counter with WAIT_CYCLES on the edge ending the setup phase, then decrement it once per access-phase cycle.
REQ-017 SHALL drive registered PREADY=1 in exactly access cycle WAIT_CYCLES+1, i.e. the first PENABLE cycle when WAIT_CYCLES=0.
REQ-018 SHALL hold PREADY=0 in all other cycles, including IDLE and outside transfers.
REQ-019 SHALL treat a transfer as complete on the edge where PSEL=1, PENABLE=1 and PREADY=1.
REQ-020 Write: memory word PADDR[AWIDTH-1:2] SHALL update at the completing edge, full 32-bit word only.
REQ-021 Read: PRDATA SHALL present the addressed word in the same cycle PREADY=1.
REQ-022 PRDATA SHALL be 0 in every cycle in which PREADY=0.
REQ-023 Misaligned address (PADDR[1:0] != 0): SHALL assert PSLVERR=1 with PREADY, suppress the memory write, and return PRDATA=0.
REQ-024 PSLVERR SHALL be 0 whenever PREADY=0.
REQ-025 Back-to-back transfers (new setup in the cycle after DONE) SHALL be accepted with no idle cycle required.
REQ-026 Abort (PSEL falls before completion): SHALL perform no write, leave XFER_CNT unchanged, and take no error action.
REQ-027 PENABLE=1 while in IDLE (protocol violation): SHALL be ignored; the FSM stays in IDLE.
REQ-028 XFER_CNT SHALL increment by 1 per completed transfer and wrap from 0xFFFF to 0x0000.

Reset
REQ-029 PRESETN low SHALL force, asynchronously: FSM=IDLE, wait counter=0, PREADY=0, PSLVERR=0, PRDATA=0, XFER_CNT=0.
REQ-030 Memory contents SHALL NOT be reset; reads of unwritten words return undefined data.
REQ-031 Reset asserted mid-transfer SHALL abandon the transfer with no memory write.

Configuration
REQ-032 Macro APB_RESP_WAIT_STATES_EN defined: WAIT_CYCLES SHALL be honoured as specified above.
REQ-033 Macro absent: the block SHALL behave as WAIT_CYCLES=0 and the wait counter SHALL not be implemented; all other behaviour is unchanged.

Structure
REQ-034 Shared package apb_resp_pkg SHALL hold:
- the FSM state enum (IDLE, WAIT, DONE);
- the wait-counter width constant (4);
- the misalignment mask constant (2'b11).
REQ-035 Storage SHALL be one sub-module, apb_resp_ram: single-port synchronous RAM, 32-bit, depth 2^(AWIDTH-2), with a write enable and a synchronous read.

Verification
REQ-036 WAIT_CYCLES=2: write 0xDEADBEEF to 0x010, then read 0x010 -> each transfer shows PREADY=1 in access cycle 3; read returns 0xDEADBEEF with PSLVERR=0; XFER_CNT=2.
REQ-037 WAIT_CYCLES=0: back-to-back writes to 0x000 and 0x004, then reads of both -> PREADY=1 in the first access cycle of each; data matches; no idle cycles between transfers.
REQ-038 Write 0x12345678 to 0x013 -> PSLVERR=1 with PREADY; a following read of 0x010 returns the prior value, unchanged.
REQ-039 Drop PSEL during the second wait cycle of a write to 0x020 -> no PREADY; read of 0x020 returns the old value; XFER_CNT unchanged.
REQ-040 Preload XFER_CNT to 0xFFFF via 65535 transfers, then complete one more transfer -> XFER_CNT=0x0000.
REQ-041 Assert PRESETN low during WAIT of a write to 0x030 -> outputs go to reset values immediately; after release, a read of 0x030 shows no write occurred.
